// File: rtl/cache_plru_victim.sv
// Tree pseudo-LRU victim selection for an 8-way set-associative L1.
// One 7-bit tree per set; registered victim/response one cycle after lookup.
module cache_plru_victim #(
  parameter int WAYS     = 8,
  parameter int WAYS_REP = 3,
  parameter int INDEX    = 3
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                req_valid,
  input  logic [INDEX-1:0]    req_index,
  input  logic                cmpr_read_hit,
  input  logic [WAYS_REP-1:0] way,
  input  logic [WAYS-1:0]     valid_bits,
  input  logic                plru_clear,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic [WAYS_REP-1:0] victim_way,
  output logic [WAYS-2:0]     plru_state
);

  localparam int SETS = 2 ** INDEX;

  typedef logic [WAYS-2:0]     tree_t;
  typedef logic [WAYS_REP-1:0] way_t;

  tree_t plru [SETS];

  tree_t cur_tree;
  tree_t nxt_tree;
  way_t  walk_way;
  way_t  low_inv;
  way_t  sel_way;
  logic  any_inv;

  // Follow the pointers from the root: 0 steers to the lower-numbered half.
  function automatic way_t plru_walk(input tree_t b);
    logic       w2;
    logic       w1;
    logic [2:0] l2;
    w2 = b[0];
    w1 = w2 ? b[2] : b[1];
    l2 = {1'b0, w2, w1} + 3'd3;
    return {w2, w1, b[l2]};
  endfunction

  // Point every node on the accessed path away from that way.
  function automatic tree_t plru_touch(input tree_t b, input way_t w);
    tree_t      n;
    logic [2:0] l1;
    logic [2:0] l2;
    n  = b;
    l1 = {2'b00, w[2]} + 3'd1;
    l2 = {1'b0, w[2], w[1]} + 3'd3;
    n[0]  = ~w[2];
    n[l1] = ~w[1];
    n[l2] = ~w[0];
    return n;
  endfunction

  always_comb begin
    low_inv = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_bits[i]) low_inv = i[WAYS_REP-1:0];
    end
  end

  assign any_inv  = ~&valid_bits;
  assign cur_tree = plru[req_index];
  assign walk_way = plru_walk(cur_tree);

  always_comb begin
    sel_way = walk_way;
    if (cmpr_read_hit)
      sel_way = way;
    else if (any_inv)
      sel_way = low_inv;
  end

  assign nxt_tree = plru_touch(cur_tree, sel_way);

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      for (int s = 0; s < SETS; s++) plru[s] <= '0;
    end else if (plru_clear) begin
      for (int s = 0; s < SETS; s++) plru[s] <= '0;
    end else if (req_valid) begin
      plru[req_index] <= nxt_tree;
    end
  end

  // The response reflects the update even when a clear wipes the array.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      victim_way <= '0;
      plru_state <= '0;
    end else begin
      resp_valid <= req_valid;
      if (req_valid) begin
        resp_hit   <= cmpr_read_hit;
        victim_way <= sel_way;
        plru_state <= nxt_tree;
      end
    end
  end

endmodule

// File: doc/cache_plru_victim.md
Name: cache_plru_victim

Overview:
- Sits directly downstream of the cache read-hit comparator (8-way set-associative L1).
- Consumes the comparator's per-lookup hit flag and hit way, and keeps one tree pseudo-LRU state per set.
- On a hit, updates that state. On a miss, selects the victim way for the refill and updates the state as if the victim had been accessed.
- The registered victim/response feeds the line-fill/eviction controller.

Parameters:
- WAYS, 8, associativity; fixed at 8 for this block, giving a 3-level tree and 7 state bits per set.
- WAYS_REP, 3, width of a way number (log2 WAYS).
- INDEX, 3, set-index width; number of sets = 2**INDEX; overridden at instantiation.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rstb  input  1  asynchronous, active-high reset (1 = in reset).
- req_valid  input  1  lookup result present this cycle.
- req_index  input  INDEX  set index of the lookup.
- cmpr_read_hit  input  1  hit flag from the comparator.
- way  input  WAYS_REP  hit way from the comparator; ignored when cmpr_read_hit=0.
- valid_bits  input  WAYS  line-valid bits of the addressed set; bit i = way i.
- plru_clear  input  1  synchronous clear of all PLRU state.
- resp_valid  output  1  response valid, exactly one cycle after req_valid.
- resp_hit  output  1  registered copy of cmpr_read_hit.
- victim_way  output  WAYS_REP  way to refill on a miss; equals the hit way on a hit.
- plru_state  output  WAYS-1  post-update PLRU bits of the responded set (debug/verification).

Behaviour:
- State: array plru[2**INDEX][7] of flops, bits b0..b6.
  - b0 = root.
  - b1, b2 = level 1 (left, right).
  - b3..b6 = level 2.
  - Bit value 0 points to the lower-numbered subtree.
- Victim walk (way = {w2,w1,w0}): w2 = b0; w1 = b[1+w2]; w0 = b[3+2*w2+w1].
- Access update for way w: b0 = ~w2; b[1+w2] = ~w1; b[3+2*w2+w1] = ~w0. All other bits are unchanged.
- Cycle N, req_valid=1: read plru[req_index].
  - Hit: selected way = way.
  - Miss with any valid_bits bit = 0: selected way = lowest-numbered invalid way.
  - Miss with all valid: selected way = PLRU victim walk.
- Posedge ending cycle N:
  - plru[req_index] gets the access update of the selected way.
  - resp_valid=1, resp_hit, victim_way and plru_state (updated bits) are registered.
- Cycle N+1: response visible. Latency is exactly 1 cycle. There is no stall or backpressure; one request per cycle is accepted.
- Back-to-back requests to the same index: the cycle N+1 request sees the state written at the end of cycle N. No read-before-write hazard is allowed.
- req_valid=0: no state change; resp_valid=0 next cycle. Other outputs hold their last values.
- plru_clear=1: all sets are cleared to 0 at that edge; clear has priority over the update.
  - A coincident request still produces its response from the pre-clear state.
  - plru_state then shows the updated value, but the array holds 0.
- Reset (rstb=1, any time, asynchronous): all plru = 0; resp_valid=0, resp_hit=0, victim_way=0, plru_state=0.
  - An in-flight request is dropped; no response is issued for it.
  - The first request after deassertion is handled normally.
- Unused inputs when req_valid=0 are don't-care. X on them must not corrupt state.

Test Plan:
- Reset, then miss on set 0 with valid_bits=8'hFF -> next cycle resp_valid=1, resp_hit=0, victim_way=0, plru_state=7'h0B.
- Two further back-to-back misses on set 0 with valid_bits=8'hFF -> victim_way 4 (plru_state 7'h2E), then victim_way 2.
- Fresh set 1: hit way=5 -> plru_state=7'h04; then miss with valid_bits=8'hFF -> victim_way=0.
- Miss on set 2 with valid_bits=8'b1111_0011 -> victim_way=2, irrespective of PLRU state; plru_state=7'h11.
- Miss on set 0 with plru_clear=1 in the same cycle -> response uses pre-clear state; the following miss on set 0 with all valid gives victim_way=0.
- Assert rstb in the cycle after req_valid, before the response edge -> resp_valid stays 0, all outputs 0, all sets read back victim 0.
